mc_cpu: RTL and testbench
=========================

// Module: mc_cpu
// PURPOSE
//  Multi-cycle 32-bit MIPS-subset processor; successor to the single-cycle core. One FSM walks
//  FETCH/DECODE/EXEC/MEM/WB, one shared register file and ALU, one unified memory port with
//  req/ready handshake (wait states allowed). Illegal-instruction halt, retire strobe for checking.
// PARAMETERS
//  RESET_PC          32'h0000_0000  PC loaded on reset
//  HALT_ON_ILLEGAL   1              1: illegal opcode/funct -> HALT; 0: executed as NOP
// PORTS
//  clock       in   1   single clock, rising edge
//  reset       in   1   asynchronous, active-low; all state cleared while low
//  mem_req     out  1   memory transaction request
//  mem_we      out  1   1=write, 0=read; valid while mem_req=1
//  mem_addr    out  32  byte address, bits [1:0] always 2'b00
//  mem_wdata   out  32  store data; valid while mem_req & mem_we
//  mem_rdata   in   32  read data; sampled on the edge where mem_req & mem_ready
//  mem_ready   in   1   transaction completes on edge where mem_req & mem_ready
//  retire      out  1   1-cycle pulse in the cycle an instruction finishes
//  halted      out  1   1 while in HALT
//  pc_out      out  32  current PC (address of next/ongoing fetch)
// BEHAVIOUR
//  Reset (reset=0, async): state=FETCH, pc=RESET_PC, all 32 GPRs=0, IR/A/B/ALUOUT/MDR=0;
//   outputs mem_req=0 (gated by reset), mem_we=0, mem_addr=RESET_PC, mem_wdata=0, retire=0, halted=0.
//   Reset mid-transaction aborts it; mem_req drops in the same cycle reset falls.
//  Supported: R funct sll 00, addu 21, subu 23, and 24, or 25, slt 2A (signed); I addiu 09 (sign-ext),
//   andi 0C / ori 0D (zero-ext), lui 0F, lw 23, sw 2B (sign-ext offset), beq 04, j 02. Else illegal.
//  mem_req=1 exactly in FETCH and MEM; addr/we/wdata held stable until mem_ready sampled 1.
//  FETCH: addr=pc, we=0; on ready: IR<=rdata, pc<=pc+4, ->DECODE; else stay.
//  DECODE: A<=GPR[rs], B<=GPR[rt]; j: pc<={pc[31:28],IR[25:0],2'b00}, retire, ->FETCH;
//   illegal: ->HALT (HALT_ON_ILLEGAL=1) or retire,->FETCH; else ->EXEC.
//  EXEC: ALUOUT<=result; ALU/lui/sll ->WB; lw/sw ->MEM (ALUOUT=A+sext(imm));
//   beq: if A==B pc<=pc+(sext(imm)<<2); retire, ->FETCH.
//  MEM: addr={ALUOUT[31:2],2'b00}; sw: we=1, wdata=B, on ready retire,->FETCH;
//   lw: we=0, on ready MDR<=rdata,->WB; else stay.
//  WB: GPR[dest]<=ALUOUT or MDR (dest=rd for R, rt for I); writes to $0 discarded; retire,->FETCH.
//  HALT: sticky until reset; mem_req=0, no GPR/pc change.
//  Latency at zero wait: j 2, beq 3, ALU 4, sw 4, lw 5 cycles; each wait cycle adds 1.
//  Arithmetic 32-bit wrap, no overflow traps; pc+4 wraps 0xFFFF_FFFC->0. Reg read in DECODE sees
//   prior WB (write completes on the edge before).
// TESTING
//  1 Reset low, mem_ready=1 -> mem_req=0, pc_out=0; release -> next cycle mem_req=1, addr=0, we=0.
//  2 0x34011234 (ori $1,$0,0x1234), 0x00211021 (addu $2,$1,$1), 0xAC020010 (sw $2,16($0)), ready=1
//    -> retire at cycles 4,8,12; third op: mem_we=1, addr=0x10, wdata=0x0000_2468.
//  3 lw $3,0($0) (0x8C030000) with ready low 3 cycles in MEM -> req/addr=0 held stable 4 cycles,
//    retire 8 cycles after fetch start; following sw $3 shows loaded value.
//  4 0x1000FFFF (beq $0,$0,-1) at 0x20 -> fetch addr 0x20 repeats every 3 cycles, retire each time.
//  5 addiu $0,$0,5 (0x24000005) then sw $0,0($0) -> wdata=0 (zero register immutable).
//  6 0xFC000000 -> halted=1 after DECODE, mem_req=0 forever; reset low mid-MEM -> req drops at once.

Source files
------------

// File: rtl/mc_cpu.sv
// mc_cpu: multi-cycle 32-bit MIPS-subset core.
// One FSM, shared ALU and register file, single req/ready memory port.
module mc_cpu #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        retire,
  output logic        halted,
  output logic [31:0] pc_out
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    I_ILL, I_SLL, I_ADDU, I_SUBU, I_AND, I_OR,
    I_SLT, I_ADDIU, I_ANDI, I_ORI, I_LUI,
    I_LW, I_SW, I_BEQ, I_J
  } ins_t;

  state_t state, state_nx;
  ins_t   ins;

  logic [31:0] pc, ir, a, b, aluout, mdr;
  logic [31:0] alu_res, sext, zext;
  logic [31:0] gpr [32];

  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd, shamt, dest;

  assign op    = ir[31:26];
  assign rs    = ir[25:21];
  assign rt    = ir[20:16];
  assign rd    = ir[15:11];
  assign shamt = ir[10:6];
  assign funct = ir[5:0];
  assign sext  = {{16{ir[15]}}, ir[15:0]};
  assign zext  = {16'h0000, ir[15:0]};
  assign dest  = (op == 6'h00) ? rd : rt;

  always_comb begin
    ins = I_ILL;
    unique case (op)
      6'h00: begin
        unique case (funct)
          6'h00:   ins = I_SLL;
          6'h21:   ins = I_ADDU;
          6'h23:   ins = I_SUBU;
          6'h24:   ins = I_AND;
          6'h25:   ins = I_OR;
          6'h2A:   ins = I_SLT;
          default: ins = I_ILL;
        endcase
      end
      6'h09:   ins = I_ADDIU;
      6'h0C:   ins = I_ANDI;
      6'h0D:   ins = I_ORI;
      6'h0F:   ins = I_LUI;
      6'h23:   ins = I_LW;
      6'h2B:   ins = I_SW;
      6'h04:   ins = I_BEQ;
      6'h02:   ins = I_J;
      default: ins = I_ILL;
    endcase
  end

  // default result doubles as the lw/sw effective address
  always_comb begin
    alu_res = a + sext;
    unique case (ins)
      I_SLL:   alu_res = b << shamt;
      I_ADDU:  alu_res = a + b;
      I_SUBU:  alu_res = a - b;
      I_AND:   alu_res = a & b;
      I_OR:    alu_res = a | b;
      I_SLT:   alu_res = {31'd0, $signed(a) < $signed(b)};
      I_ANDI:  alu_res = a & zext;
      I_ORI:   alu_res = a | zext;
      I_LUI:   alu_res = {ir[15:0], 16'h0000};
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    retire   = 1'b0;
    unique case (state)
      S_FETCH: if (mem_ready) state_nx = S_DECODE;
      S_DECODE: begin
        if (ins == I_J) begin
          retire   = 1'b1;
          state_nx = S_FETCH;
        end else if (ins == I_ILL) begin
          if (HALT_ON_ILLEGAL) begin
            state_nx = S_HALT;
          end else begin
            retire   = 1'b1;
            state_nx = S_FETCH;
          end
        end else begin
          state_nx = S_EXEC;
        end
      end
      S_EXEC: begin
        if (ins == I_BEQ) begin
          retire   = 1'b1;
          state_nx = S_FETCH;
        end else if (ins == I_LW || ins == I_SW) begin
          state_nx = S_MEM;
        end else begin
          state_nx = S_WB;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          if (ins == I_SW) begin
            retire   = 1'b1;
            state_nx = S_FETCH;
          end else begin
            state_nx = S_WB;
          end
        end
      end
      S_WB: begin
        retire   = 1'b1;
        state_nx = S_FETCH;
      end
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_FETCH;
    endcase
  end

  // reset gates the request so an aborted access drops immediately
  always_comb begin
    mem_req   = reset & (state == S_FETCH || state == S_MEM);
    mem_we    = (state == S_MEM) && (ins == I_SW);
    mem_addr  = pc;
    mem_wdata = '0;
    if (state == S_MEM) mem_addr = aluout & 32'hFFFF_FFFC;
    if (mem_we) mem_wdata = b;
  end

  assign halted = (state == S_HALT);
  assign pc_out = pc;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= S_FETCH;
      pc     <= RESET_PC;
      ir     <= '0;
      a      <= '0;
      b      <= '0;
      aluout <= '0;
      mdr    <= '0;
      for (int i = 0; i < 32; i++) gpr[i] <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        S_FETCH: begin
          if (mem_ready) begin
            ir <= mem_rdata;
            pc <= pc + 32'd4;
          end
        end
        S_DECODE: begin
          a <= gpr[rs];
          b <= gpr[rt];
          if (ins == I_J) pc <= {pc[31:28], ir[25:0], 2'b00};
        end
        S_EXEC: begin
          aluout <= alu_res;
          if (ins == I_BEQ && a == b) pc <= pc + (sext << 2);
        end
        S_MEM: if (mem_ready && ins == I_LW) mdr <= mem_rdata;
        S_WB: begin
          if (dest != 5'd0) gpr[dest] <= (ins == I_LW) ? mdr : aluout;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_cpu.sv
// tb_mc_cpu: directed scenarios plus random programs
// checked against an instruction-level reference model.
module tb_mc_cpu;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        mem_ready = 1'b1;
  logic [31:0] mem_rdata = '0;
  logic        mem_req, mem_we, retire, halted;
  logic [31:0] mem_addr, mem_wdata, pc_out;

  mc_cpu dut (
    .clock    (clock),
    .reset    (reset),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .retire   (retire),
    .halted   (halted),
    .pc_out   (pc_out)
  );

  always #5 clock = ~clock;

  localparam logic [31:0] ILL = 32'hFC00_0000;

  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic [31:0] rf [32];
  logic [31:0] mpc;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;
  bit rnd_mode = 1'b0;
  logic [63:0] nready = '0;

  logic        s_req, s_we, s_ret, s_halt;
  logic [31:0] s_addr, s_wdata, s_pc;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
    cyc_n++;
    if (rnd_mode) mem_ready = ($urandom_range(0, 2) != 0);
    else mem_ready = !(cyc_n < 64 && nready[cyc_n[5:0]]);
    mem_rdata = mem[mem_addr[9:2]];
    #1;
    s_req   = mem_req;
    s_we    = mem_we;
    s_addr  = mem_addr;
    s_wdata = mem_wdata;
    s_ret   = retire;
    s_halt  = halted;
    s_pc    = pc_out;
    if (mem_req && mem_we && mem_ready) mem[mem_addr[9:2]] = mem_wdata;
  endtask

  task automatic start(input logic [63:0] nr);
    @(negedge clock);
    reset     = 1'b0;
    mem_ready = 1'b1;
    nready    = nr;
    rnd_mode  = 1'b0;
    s_halt    = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    check("rst_req", mem_req, 0);
    check("rst_pc", pc_out, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_we", mem_we, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_ret", retire, 0);
    check("rst_halt", halted, 0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    cyc_n = 0;
  endtask

  task automatic clear_mem();
    foreach (mem[i]) mem[i] = '0;
  endtask

  function automatic logic [31:0] gen(input int i);
    logic [5:0]  fns [6] = '{6'h00, 6'h21, 6'h23, 6'h24, 6'h25, 6'h2A};
    logic [4:0]  rs  = 5'($urandom_range(0, 7));
    logic [4:0]  rt  = 5'($urandom_range(0, 7));
    logic [4:0]  rd  = 5'($urandom_range(0, 7));
    logic [15:0] imm = 16'($urandom);
    logic [15:0] off = 16'(32'h200 + 4 * $urandom_range(0, 63));
    logic [5:0]  fn;
    case ($urandom_range(0, 9))
      0, 1: begin
        fn = fns[$urandom_range(0, 5)];
        return {6'h00, rs, rt, rd, (fn == 6'h00) ? imm[10:6] : 5'd0, fn};
      end
      2: return {6'h09, rs, rt, imm};
      3: return {6'h0C, rs, rt, imm};
      4: return {6'h0D, rs, rt, imm};
      5: return {6'h0F, rs, rt, imm};
      6: return {6'h23, 5'd0, rt, off};
      7: return {6'h2B, 5'd0, rt, off};
      8: begin
        if ($urandom_range(0, 1) == 1) rt = rs;
        return {6'h04, rs, rt, 16'd1};
      end
      default: return {6'h02, 26'(i + 2)};
    endcase
  endfunction

  // instruction-set level model: one call per retired instruction
  task automatic model_step(output int lat, output bit st,
                            output logic [31:0] sa, output logic [31:0] sd,
                            output bit ill);
    logic [31:0] w, se, ze, npc, val, ea;
    logic [4:0]  dst;
    bit          wr;
    w   = ref_mem[mpc[9:2]];
    se  = {{16{w[15]}}, w[15:0]};
    ze  = {16'h0, w[15:0]};
    npc = mpc + 4;
    ea  = rf[w[25:21]] + se;
    lat = 4; st = 0; sa = 0; sd = 0; ill = 0;
    wr  = 1; dst = w[20:16]; val = 0;
    case (w[31:26])
      6'h00: begin
        dst = w[15:11];
        case (w[5:0])
          6'h00: val = rf[w[20:16]] << w[10:6];
          6'h21: val = rf[w[25:21]] + rf[w[20:16]];
          6'h23: val = rf[w[25:21]] - rf[w[20:16]];
          6'h24: val = rf[w[25:21]] & rf[w[20:16]];
          6'h25: val = rf[w[25:21]] | rf[w[20:16]];
          6'h2A: val = ($signed(rf[w[25:21]]) < $signed(rf[w[20:16]])) ? 1 : 0;
          default: ill = 1;
        endcase
      end
      6'h09: val = rf[w[25:21]] + se;
      6'h0C: val = rf[w[25:21]] & ze;
      6'h0D: val = rf[w[25:21]] | ze;
      6'h0F: val = {w[15:0], 16'h0};
      6'h23: begin lat = 5; val = ref_mem[ea[9:2]]; end
      6'h2B: begin
        wr = 0; st = 1;
        sa = {ea[31:2], 2'b00};
        sd = rf[w[20:16]];
        ref_mem[ea[9:2]] = sd;
      end
      6'h04: begin
        lat = 3; wr = 0;
        if (rf[w[25:21]] == rf[w[20:16]]) npc = npc + (se << 2);
      end
      6'h02: begin lat = 2; wr = 0; npc = {npc[31:28], w[25:0], 2'b00}; end
      default: ill = 1;
    endcase
    if (!ill) begin
      if (wr && dst != 0) rf[dst] = val;
      mpc = npc;
    end
  endtask

  task automatic random_prog();
    int lat, lat_cnt, waits, diff;
    bit st, ill, fchk;
    logic [31:0] sa, sd;
    clear_mem();
    for (int i = 0; i < 54; i++) mem[i] = gen(i);
    for (int k = 0; k < 8; k++) mem[54 + k] = {6'h2B, 5'd0, 5'(k), 16'(32'h2E0 + 4 * k)};
    mem[62] = ILL;
    for (int i = 128; i < 192; i++) mem[i] = $urandom;
    foreach (mem[i]) ref_mem[i] = mem[i];
    foreach (rf[i]) rf[i] = '0;
    mpc = '0;
    start('0);
    rnd_mode = 1'b1;
    lat_cnt = 0; waits = 0; fchk = 1;
    for (int c = 0; c < 4000 && !s_halt; c++) begin
      cyc();
      if (fchk) begin
        check("r_freq", s_req, 1);
        check("r_fetch", s_addr, mpc);
        fchk = 0;
      end
      lat_cnt++;
      if (s_req && !mem_ready) waits++;
      if (s_ret) begin
        model_step(lat, st, sa, sd, ill);
        check("r_ill", ill, 0);
        check("r_lat", lat_cnt, lat + waits);
        check("r_we", s_we, st);
        if (st) begin
          check("r_saddr", s_addr, sa);
          check("r_sdata", s_wdata, sd);
        end
        lat_cnt = 0; waits = 0; fchk = 1;
      end
    end
    check("r_halt", s_halt, 1);
    model_step(lat, st, sa, sd, ill);
    check("r_end_ill", ill, 1);
    diff = 0;
    for (int i = 128; i < 192; i++) if (mem[i] !== ref_mem[i]) diff++;
    check("r_memdiff", diff, 0);
  endtask

  initial begin
    logic [31:0] v;

    // ori / addu / sw at zero wait
    clear_mem();
    mem[0] = 32'h3401_1234;
    mem[1] = 32'h0021_1021;
    mem[2] = 32'hAC02_0010;
    mem[3] = ILL;
    start('0);
    for (int c = 1; c <= 12; c++) begin
      cyc();
      if (c == 1) begin
        check("t1_req", s_req, 1);
        check("t1_addr", s_addr, 0);
        check("t1_we", s_we, 0);
      end
      check($sformatf("t2_ret%0d", c), s_ret, (c == 4 || c == 8 || c == 12));
      if (c == 12) begin
        check("t2_we", s_we, 1);
        check("t2_addr", s_addr, 32'h10);
        check("t2_wdata", s_wdata, 32'h2468);
      end
    end

    // lw with three MEM wait states, then sw of the loaded value
    clear_mem();
    v = $urandom;
    mem[0]  = 32'h8C03_0040;
    mem[1]  = 32'hAC03_0044;
    mem[2]  = ILL;
    mem[16] = v;
    start(64'h70);
    for (int c = 1; c <= 12; c++) begin
      cyc();
      if (c >= 4 && c <= 7) begin
        check("t3_req", s_req, 1);
        check("t3_addr", s_addr, 32'h40);
        check("t3_we", s_we, 0);
      end
      if (c <= 8) check($sformatf("t3_ret%0d", c), s_ret, c == 8);
      if (c == 12) begin
        check("t3_sret", s_ret, 1);
        check("t3_saddr", s_addr, 32'h44);
        check("t3_sdata", s_wdata, v);
      end
    end

    // j to 0x20, then beq $0,$0,-1 spins there
    clear_mem();
    mem[0] = 32'h0800_0008;
    mem[8] = 32'h1000_FFFF;
    start('0);
    for (int c = 1; c <= 14; c++) begin
      cyc();
      if (c >= 3 && c % 3 == 0) begin
        check("t4_freq", s_req, 1);
        check("t4_faddr", s_addr, 32'h20);
      end
      check($sformatf("t4_ret%0d", c), s_ret, (c == 2 || (c >= 5 && c % 3 == 2)));
    end

    // $0 stays zero
    clear_mem();
    mem[0] = 32'h2400_0005;
    mem[1] = 32'hAC00_0040;
    mem[2] = ILL;
    start('0);
    for (int c = 1; c <= 8; c++) begin
      cyc();
      if (c == 8) begin
        check("t5_we", s_we, 1);
        check("t5_addr", s_addr, 32'h40);
        check("t5_wdata", s_wdata, 0);
      end
    end

    // illegal opcode halts for good
    clear_mem();
    mem[0] = ILL;
    start('0);
    for (int c = 1; c <= 10; c++) begin
      cyc();
      check($sformatf("t6_halt%0d", c), s_halt, c >= 3);
      if (c >= 3) check("t6_req", s_req, 0);
      check("t6_ret", s_ret, 0);
      if (c >= 3) check("t6_pc", s_pc, 32'h4);
    end

    // reset during a stalled MEM access
    clear_mem();
    mem[0] = 32'h8C03_0040;
    start(64'h00FF_FFF0);
    for (int c = 1; c <= 5; c++) cyc();
    check("t6_mreq", s_req, 1);
    check("t6_maddr", s_addr, 32'h40);
    reset = 1'b0;
    #1;
    check("t6_abort_req", mem_req, 0);
    check("t6_abort_pc", pc_out, 0);
    check("t6_abort_addr", mem_addr, 0);

    for (int r = 0; r < 4; r++) random_prog();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
